me_mem_arb: RTL

Burst arbiter that shares the single reference-frame memory port (ref_mem: enable, 32-bit word address, 64-bit data) between two requesters of the motion-estimation engine. Requester 0 is the RefSRAM search-window fill; requester 1 is the current-block buffer fill. The arbiter accepts one burst request at a time and drives sequential word addresses into ref_mem. It tracks in-flight reads and steers returned data to the owning requester with valid/last framing. Round-robin arbitration between bursts.

---
 rtl/me_mem_arb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/me_mem_arb.sv
// Round-robin burst arbiter sharing the reference-frame memory read port between
// the search-window fill (requester 0) and the current-block fill (requester 1).
module me_mem_arb #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rd0_valid,
  output logic              rd0_last,
  output logic              rd1_valid,
  output logic              rd1_last,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              owner
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                owner_q, owner_d;
  logic                mem_en_q, mem_en_d;
  logic                last_q, last_d;
  logic                sel;
  logic [LEN_W-1:0]    len_sel;

  // Per-owner return pipelines: one stage per cycle of memory read latency.
  logic [RD_LAT-1:0]   v0_q, v1_q, l0_q, l1_q;

  // Next-state, grant and address sequencing; cnt counts words left after the current one.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    mem_en_d   = 1'b0;
    last_d     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sel        = (req0_valid && req1_valid) ? ~owner_q : req1_valid;
    len_sel    = sel ? req1_len : req0_len;

    case (state_q)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          req0_ready = ~sel;
          req1_ready = sel;
          owner_d    = sel;
          addr_d     = sel ? req1_addr : req0_addr;
          cnt_d      = len_sel - LEN_W'(1);
          last_d     = (len_sel == LEN_W'(1));
          mem_en_d   = 1'b1;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          addr_d   = addr_q + ADDR_W'(1);
          cnt_d    = cnt_q - LEN_W'(1);
          last_d   = (cnt_q == LEN_W'(1));
          mem_en_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, issue registers and return-tag shift registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      owner_q  <= 1'b1;
      mem_en_q <= 1'b0;
      last_q   <= 1'b0;
      v0_q     <= '0;
      v1_q     <= '0;
      l0_q     <= '0;
      l1_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      mem_en_q <= mem_en_d;
      last_q   <= last_d;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        v0_q[i] <= v0_q[i-1];
        v1_q[i] <= v1_q[i-1];
        l0_q[i] <= l0_q[i-1];
        l1_q[i] <= l1_q[i-1];
      end
      v0_q[0] <= mem_en_q & ~owner_q;
      v1_q[0] <= mem_en_q & owner_q;
      l0_q[0] <= mem_en_q & ~owner_q & last_q;
      l1_q[0] <= mem_en_q & owner_q & last_q;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_addr  = addr_q;
  assign owner     = owner_q;
  assign rd0_valid = v0_q[RD_LAT-1];
  assign rd1_valid = v1_q[RD_LAT-1];
  assign rd0_last  = l0_q[RD_LAT-1];
  assign rd1_last  = l1_q[RD_LAT-1];
  assign rd_data   = mem_data;
  assign busy      = (state_q == BURST) || (|v0_q) || (|v1_q);

endmodule
